// File: rtl/fsk_frame_ctrl.sv
// 2FSK frame scheduler: paces the bit source and wraps the payload in preamble + sync word.
// Optional even-parity trailer bit when FSK_PARITY_EN is defined.
module fsk_frame_ctrl #(
  parameter int                CLK_DIV      = 16,
  parameter int                PREAMBLE_LEN = 8,
  parameter logic [7:0]        SYNC_WORD    = 8'hD3,
  parameter int                PAYLOAD_LEN  = 32,
  parameter int                FW_W         = 32,
  parameter logic [FW_W-1:0]   FW0          = 32'h0100_0000,
  parameter logic [FW_W-1:0]   FW1          = 32'h0200_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            src_code,
  output logic            src_en,
  output logic            bit_out,
  output logic            bit_stb,
  output logic [FW_W-1:0] fword,
  output logic            tx_on,
  output logic            busy,
  output logic            done
);

`ifdef FSK_PARITY_EN
  typedef enum logic [2:0] {IDLE, PRE, SYNC, PAY, PAR} state_t;
  logic parity;
`else
  typedef enum logic [2:0] {IDLE, PRE, SYNC, PAY} state_t;
`endif

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] DIV_M2 = 16'(CLK_DIV - 2);
  localparam logic [15:0] PRE_M1 = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] PAY_M1 = 16'(PAYLOAD_LEN - 1);

  state_t      state, nxt_state;
  logic [15:0] cnt, bitcnt, nxt_bitcnt;
  logic        nxt_bit, last, pay_next;
  logic [2:0]  sync_idx;

  // bitcnt holds the bits still to come in the current state after the one on air
  assign sync_idx = 3'(bitcnt - 16'd1);
  assign pay_next = (state == SYNC && bitcnt == 16'd0) || (state == PAY && bitcnt != 16'd0);

  always_comb begin
    nxt_state  = state;
    nxt_bit    = 1'b0;
    nxt_bitcnt = bitcnt - 16'd1;
    last       = 1'b0;
    case (state)
      PRE:
        if (bitcnt != 16'd0) nxt_bit = ~bit_out;
        else begin
          nxt_state  = SYNC;
          nxt_bit    = SYNC_WORD[7];
          nxt_bitcnt = 16'd7;
        end
      SYNC:
        if (bitcnt != 16'd0) nxt_bit = SYNC_WORD[sync_idx];
        else begin
          nxt_state  = PAY;
          nxt_bit    = src_code;
          nxt_bitcnt = PAY_M1;
        end
      PAY:
        if (bitcnt != 16'd0) nxt_bit = src_code;
        else begin
`ifdef FSK_PARITY_EN
          nxt_state  = PAR;
          nxt_bit    = parity;
          nxt_bitcnt = 16'd0;
`else
          nxt_state  = IDLE;
          nxt_bitcnt = 16'd0;
          last       = 1'b1;
`endif
        end
`ifdef FSK_PARITY_EN
      PAR: begin
        nxt_state  = IDLE;
        nxt_bitcnt = 16'd0;
        last       = 1'b1;
      end
`endif
      default: nxt_bitcnt = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      bitcnt  <= 16'd0;
      src_en  <= 1'b0;
      bit_out <= 1'b0;
      bit_stb <= 1'b0;
      fword   <= FW0;
      tx_on   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef FSK_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      src_en  <= 1'b0;
      bit_stb <= 1'b0;
      if (state == IDLE) begin
        cnt <= 16'd0;
        if (start) begin
          state   <= PRE;
          bitcnt  <= PRE_M1;
          bit_out <= 1'b1;
          fword   <= FW1;
          bit_stb <= 1'b1;
          busy    <= 1'b1;
          tx_on   <= 1'b1;
`ifdef FSK_PARITY_EN
          parity  <= 1'b0;
`endif
        end
      end else if (cnt == DIV_M1) begin
        cnt <= 16'd0;
        if (last) begin
          state   <= IDLE;
          bitcnt  <= 16'd0;
          bit_out <= 1'b0;
          fword   <= FW0;
          busy    <= 1'b0;
          tx_on   <= 1'b0;
          done    <= 1'b1;
        end else begin
          state   <= nxt_state;
          bitcnt  <= nxt_bitcnt;
          bit_out <= nxt_bit;
          fword   <= nxt_bit ? FW1 : FW0;
          bit_stb <= 1'b1;
`ifdef FSK_PARITY_EN
          if (nxt_state == PAY) parity <= parity ^ src_code;
`endif
        end
      end else begin
        cnt    <= cnt + 16'd1;
        // raise the request so it covers exactly the last cycle of the bit period
        src_en <= pay_next && (cnt == DIV_M2);
      end
    end
  end

endmodule

// File: tb/tb_fsk_frame_ctrl.sv
// Self-checking bench for fsk_frame_ctrl: table-driven frames, random payloads, corner sequences.
module tb_fsk_frame_ctrl;
  localparam int CD = 4, PL = 4, PY = 8;
  localparam int CD2 = 2, PL2 = 1, PY2 = 1;
`ifdef FSK_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam logic [31:0] F0 = 32'h0100_0000, F1 = 32'h0200_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, src_code = 1'b0, src_en, bit_out, bit_stb, tx_on, busy, done;
  logic [31:0] fword;
  logic start2 = 1'b0, src_code2 = 1'b0, src_en2, bit_out2, bit_stb2, tx_on2, busy2, done2;
  logic [31:0] fword2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fsk_frame_ctrl #(.CLK_DIV(CD), .PREAMBLE_LEN(PL), .SYNC_WORD(8'hD3), .PAYLOAD_LEN(PY),
                   .FW_W(32), .FW0(F0), .FW1(F1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_code(src_code), .src_en(src_en),
    .bit_out(bit_out), .bit_stb(bit_stb), .fword(fword), .tx_on(tx_on), .busy(busy), .done(done));

  fsk_frame_ctrl #(.CLK_DIV(CD2), .PREAMBLE_LEN(PL2), .SYNC_WORD(8'hD3), .PAYLOAD_LEN(PY2),
                   .FW_W(32), .FW0(F0), .FW1(F1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .src_code(src_code2), .src_en(src_en2),
    .bit_out(bit_out2), .bit_stb(bit_stb2), .fword(fword2), .tx_on(tx_on2), .busy(busy2), .done(done2));

  typedef struct {
    logic [7:0] pl;
    int         exp_cyc;
    int         exp_ens;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference frame: alternating preamble, sync MSB first, payload MSB first, optional parity.
  task automatic model(input int plen, input int npay, input logic [7:0] pl,
                       output logic [63:0] seq, output int n);
    logic [7:0] sw;
    logic par;
    sw = 8'hD3; seq = '0; n = 0; par = 1'b0;
    for (int i = 0; i < plen; i++) begin seq = {seq[62:0], (i % 2 == 0)}; n++; end
    for (int i = 7; i >= 0; i--) begin seq = {seq[62:0], sw[i]}; n++; end
    for (int i = 0; i < npay; i++) begin
      seq = {seq[62:0], pl[7-i]}; par ^= pl[7-i]; n++;
    end
    if (PB == 1) begin seq = {seq[62:0], par}; n++; end
  endtask

  task automatic run_frame(input logic [7:0] pl, input int exp_cyc, input int exp_ens,
                           input bit already, input bit keep, input bit poke,
                           input int rst_at, input string tag);
    logic [63:0] act, exp;
    int n, na, ens, dcyc, idx;
    bit txok, fwok;
    model(PL, PY, pl, exp, n);
    act = '0; na = 0; ens = 0; dcyc = -1; idx = 0; txok = 1; fwok = 1;
    if (!already) start = 1'b1;
    @(negedge clk);
    if (!keep) start = 1'b0;
    chk({tag, " acc busy"}, busy, 1);
    chk({tag, " acc tx_on"}, tx_on, 1);
    chk({tag, " acc bit_out"}, bit_out, 1);
    chk({tag, " acc bit_stb"}, bit_stb, 1);
    chk({tag, " acc fword"}, fword, F1);
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) @(negedge clk);
      if (poke) start = (k == 10 || k == 25 || k == 40);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, " rst busy"}, busy, 0);
        chk({tag, " rst tx_on"}, tx_on, 0);
        chk({tag, " rst bit_out"}, bit_out, 0);
        chk({tag, " rst fword"}, fword, F0);
        chk({tag, " rst src_en"}, src_en, 0);
        chk({tag, " rst bit_stb"}, bit_stb, 0);
        repeat (2) begin
          @(negedge clk);
          chk({tag, " rst done"}, done, 0);
          chk({tag, " rst src_en hold"}, src_en, 0);
        end
        rst_n = 1'b1;
        return;
      end
      if (done) begin dcyc = k; break; end
      if (src_en) begin
        if (idx < 8) src_code = pl[7-idx];
        idx++; ens++;
      end
      if (bit_stb) begin act = {act[62:0], bit_out}; na++; end
      if (fword !== (bit_out ? F1 : F0)) fwok = 0;
      if (!tx_on || !busy) txok = 0;
    end
    chk({tag, " done cycle"}, dcyc, exp_cyc);
    chk({tag, " nbits"}, na, n);
    chk({tag, " bits"}, act, exp);
    chk({tag, " src_en count"}, ens, exp_ens);
    chk({tag, " fword track"}, fwok, 1);
    chk({tag, " tx_on held"}, txok, 1);
    chk({tag, " end bit_out"}, bit_out, 0);
    chk({tag, " end fword"}, fword, F0);
    chk({tag, " end tx_on"}, tx_on, 0);
    chk({tag, " end busy"}, busy, 0);
  endtask

  initial begin
    vec_t vt[8];
    int fcyc, extra;
    logic [63:0] act, exp;
    int n, na, ens, enk, dcyc;
    logic b;

    fcyc = (PL + 8 + PY + PB) * CD;
    vt[0] = '{8'b1010_1010, fcyc, PY};
    vt[1] = '{8'b1110_0000, fcyc, PY};
    vt[2] = '{8'h00, fcyc, PY};
    vt[3] = '{8'hFF, fcyc, PY};
    for (int i = 4; i < 8; i++) vt[i] = '{8'($urandom), fcyc, PY};

    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset tx_on", tx_on, 0);
    chk("reset bit_out", bit_out, 0);
    chk("reset fword", fword, F0);
    chk("reset done", done, 0);
    chk("reset src_en", src_en, 0);
    chk("reset bit_stb", bit_stb, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle stays idle", busy, 0);

    for (int i = 0; i < 8; i++) begin
      run_frame(vt[i].pl, vt[i].exp_cyc, vt[i].exp_ens, 0, 0, 0, -1, $sformatf("v%0d", i));
      if (i % 2 == 1) repeat (2) @(negedge clk);
    end

    // back-to-back: start held across the done cycle
    run_frame(8'h5C, fcyc, PY, 0, 1, 0, -1, "b2b1");
    run_frame(8'h3A, fcyc, PY, 1, 0, 0, -1, "b2b2");
    repeat (2) @(negedge clk);

    // start pulses while busy must not disturb the frame
    run_frame(8'h96, fcyc, PY, 0, 0, 1, -1, "poke");
    extra = 0;
    repeat (20) begin @(negedge clk); if (done) extra++; end
    chk("poke single done", extra, 0);
    chk("poke idle after", busy, 0);

    // reset during the 3rd payload bit, then a clean frame
    run_frame(8'hC3, fcyc, PY, 0, 0, 0, (PL + 8 + 2) * CD + 1, "rstmid");
    @(negedge clk);
    chk("post-rst idle", busy, 0);
    run_frame(8'h71, fcyc, PY, 0, 0, 0, -1, "after_rst");

    // minimum divider instance
    b = 1'($urandom);
    model(PL2, PY2, {b, 7'b0}, exp, n);
    act = '0; na = 0; ens = 0; enk = -1; dcyc = -1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (k > 0) @(negedge clk);
      if (done2) begin dcyc = k; break; end
      if (src_en2) begin src_code2 = b; ens++; enk = k; end
      if (bit_stb2) begin act = {act[62:0], bit_out2}; na++; end
    end
    chk("min done cycle", dcyc, (PL2 + 8 + PY2 + PB) * CD2);
    chk("min src_en count", ens, 1);
    chk("min src_en cycle", enk, (PL2 + 8) * CD2 - 1);
    chk("min nbits", na, n);
    chk("min bits", act, exp);
    chk("min end tx_on", tx_on2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
